// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and start decode for the execute-stage MDU.
// The madd/maddu/msub/msubu family is only decoded as startable when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_state_e;

  // Also used by the hazard unit to decide whether a D-stage op must wait.
  function automatic logic is_mdu_start(input logic [3:0] op);
    logic res;
    res = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_e_if.sv
// Pipeline-side bundle of the E-stage MDU: op/operands in, handshake and HI/LO out.
interface mdu_e_if;
  logic [3:0]  MDUOpE;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        start;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDUOpE, E_V1, E_V2,
    input  start, busy, mdu_out, HI, LO
  );

  modport slave (
    input  MDUOpE, E_V1, E_V2,
    output start, busy, mdu_out, HI, LO
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: {hi', lo'} from op, operands and the current HI:LO.
// Accumulating ops (codes 9-12) are only present when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_bs;
  logic [31:0]        div_bu;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Zero divisors and the INT_MIN/-1 overflow divide by 1 instead; the zero case is
  // discarded below and INT_MIN/1 yields the wrapped quotient with a zero remainder.
  assign div_bs = ((b == 32'd0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))) ? 32'd1 : b;
  assign div_bu = (b == 32'd0) ? 32'd1 : b;
  assign quot_s = $signed(a) / $signed(div_bs);
  assign rem_s  = $signed(a) % $signed(div_bs);
  assign quot_u = a / div_bu;
  assign rem_u  = a % div_bu;

  always_comb begin
    {hi_res, lo_res} = {hi, lo};
    case (op)
      MDU_MULT:  {hi_res, lo_res} = prod_s;
      MDU_MULTU: {hi_res, lo_res} = prod_u;
      MDU_DIV: begin
        if (b != 32'd0) begin
          hi_res = rem_s;
          lo_res = quot_s;
        end
      end
      MDU_DIVU: begin
        if (b != 32'd0) begin
          hi_res = rem_u;
          lo_res = quot_u;
        end
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {hi_res, lo_res} = {hi, lo} + prod_s;
      MDU_MADDU: {hi_res, lo_res} = {hi, lo} + prod_u;
      MDU_MSUB:  {hi_res, lo_res} = {hi, lo} - prod_s;
      MDU_MSUBU: {hi_res, lo_res} = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit: owns HI/LO, models latency with a busy counter.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops.
module mdu_e
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input logic    clk,
  input logic    reset,
  mdu_e_if.slave bus
);
  mdu_state_e  state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] shadow_hi_reg, shadow_hi_next;
  logic [31:0] shadow_lo_reg, shadow_lo_next;
  logic [31:0] calc_hi, calc_lo;
  logic        start_int;
  logic        is_div;

  mdu_calc u_calc (
    .op     (bus.MDUOpE),
    .a      (bus.E_V1),
    .b      (bus.E_V2),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .hi_res (calc_hi),
    .lo_res (calc_lo)
  );

  assign start_int = is_mdu_start(bus.MDUOpE) && (state_reg == ST_IDLE);
  assign is_div    = (bus.MDUOpE == MDU_DIV) || (bus.MDUOpE == MDU_DIVU);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 32'd0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      shadow_hi_reg <= 32'd0;
      shadow_lo_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      shadow_hi_reg <= shadow_hi_next;
      shadow_lo_reg <= shadow_lo_next;
    end
  end

  // Any op arriving while busy is dropped; only the pending commit can change HI/LO.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    shadow_hi_next = shadow_hi_reg;
    shadow_lo_next = shadow_lo_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_int) begin
          shadow_hi_next = calc_hi;
          shadow_lo_next = calc_lo;
          cnt_next       = is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
          state_next     = ST_BUSY;
        end else if (bus.MDUOpE == MDU_MTHI) begin
          hi_next = bus.E_V1;
        end else if (bus.MDUOpE == MDU_MTLO) begin
          lo_next = bus.E_V1;
        end
      end
      ST_BUSY: begin
        cnt_next = cnt_reg - 32'd1;
        if (cnt_reg == 32'd1) begin
          hi_next    = shadow_hi_reg;
          lo_next    = shadow_lo_reg;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.start   = start_int;
  assign bus.busy    = (state_reg == ST_BUSY);
  assign bus.HI      = hi_reg;
  assign bus.LO      = lo_reg;
  assign bus.mdu_out = (bus.MDUOpE == MDU_MFHI) ? hi_reg :
                       (bus.MDUOpE == MDU_MFLO) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed scenarios plus randomized ops against a cycle model.
`timescale 1ns/1ps
module tb_mdu_e;
  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  mdu_e_if bus ();

  mdu_e #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: architectural HI/LO, remaining busy cycles, pending result.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0;
  logic [31:0] p_lo = 32'd0;
  int          m_left = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_is_start(input logic [3:0] op);
    return ((op >= 4'd1) && (op <= 4'd4)) || (MADD_EN && (op >= 4'd9) && (op <= 4'd12));
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint          sa  = longint'($signed(a));
    longint          sb  = longint'($signed(b));
    longint unsigned ua  = {32'd0, a};
    longint unsigned ub  = {32'd0, b};
    int              si  = $signed(a);
    int              ti  = $signed(b);
    logic [63:0]     acc = {hi, lo};
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: if (b == 32'd0) return acc; else return {32'(si % ti), 32'(si / ti)};
      4'd4: if (b == 32'd0) return acc; else return {a % b, a / b};
      4'd9:  return acc + 64'(sa * sb);
      4'd10: return acc + ua * ub;
      4'd11: return acc - 64'(sa * sb);
      4'd12: return acc - ua * ub;
      default: return acc;
    endcase
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, clock, check registered state.
  task automatic cycle(input logic rst_n, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic        exp_start;
    logic [31:0] exp_out;
    logic [63:0] res;
    reset      = rst_n;
    bus.MDUOpE = op;
    bus.E_V1   = a;
    bus.E_V2   = b;
    #1;
    exp_start = ref_is_start(op) && (m_left == 0);
    exp_out   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    check_val("start", {31'd0, bus.start}, {31'd0, exp_start});
    check_val("mdu_out", bus.mdu_out, exp_out);
    if (rst_n && (exp_start || (m_left == 0 && (op == 4'd7 || op == 4'd8))))
      $display("[TB] t=%0t op=%0d a=%h b=%h", $time, op, a, b);
    @(posedge clk);
    if (!rst_n) begin
      m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; m_left = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (exp_start) begin
      res    = ref_result(op, a, b, m_hi, m_lo);
      p_hi   = res[63:32];
      p_lo   = res[31:0];
      m_left = (op == 4'd3 || op == 4'd4) ? N_DIV : N_MULT;
    end else if (op == 4'd7) begin
      m_hi = a;
    end else if (op == 4'd8) begin
      m_lo = a;
    end
    #1;
    check_val("busy", {31'd0, bus.busy}, {31'd0, (m_left != 0)});
    check_val("HI", bus.HI, m_hi);
    check_val("LO", bus.LO, m_lo);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    bus.MDUOpE = 4'd0;
    bus.E_V1   = 32'd0;
    bus.E_V2   = 32'd0;
    cycle(1'b0, 4'd0, 32'd0, 32'd0);
    cycle(1'b0, 4'd0, 32'd0, 32'd0);
    check_val("reset_hi", bus.HI, 32'd0);
    check_val("reset_busy", {31'd0, bus.busy}, 32'd0);

    // mult -1 * 2
    cycle(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd2);
    idle(4);
    check_val("mult_busy_c5", {31'd0, bus.busy}, 32'd1);
    idle(1);
    check_val("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check_val("mult_lo", bus.LO, 32'hFFFF_FFFE);
    cycle(1'b1, 4'd5, 32'd0, 32'd0);
    check_val("mfhi_out", bus.mdu_out, 32'hFFFF_FFFF);

    // multu with the same operands
    cycle(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2);
    idle(N_MULT);
    check_val("multu_hi", bus.HI, 32'h0000_0001);
    check_val("multu_lo", bus.LO, 32'hFFFF_FFFE);

    // div -7 / 2, then divu 7 / 2
    cycle(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(N_DIV - 1);
    check_val("div_busy_c10", {31'd0, bus.busy}, 32'd1);
    idle(1);
    check_val("div_lo", bus.LO, 32'hFFFF_FFFD);
    check_val("div_hi", bus.HI, 32'hFFFF_FFFF);
    cycle(1'b1, 4'd4, 32'd7, 32'd2);
    idle(N_DIV);
    check_val("divu_lo", bus.LO, 32'd3);
    check_val("divu_hi", bus.HI, 32'd1);

    // mthi then divide by zero leaves HI/LO alone
    cycle(1'b1, 4'd7, 32'h1234_5678, 32'd0);
    cycle(1'b1, 4'd4, 32'd99, 32'd0);
    idle(N_DIV);
    check_val("div0_hi", bus.HI, 32'h1234_5678);
    check_val("div0_lo", bus.LO, 32'd3);

    // reset during busy cycle 4 discards the in-flight divide
    cycle(1'b1, 4'd3, 32'd100, 32'd7);
    idle(3);
    cycle(1'b0, 4'd0, 32'd0, 32'd0);
    check_val("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    idle(N_DIV + 2);
    check_val("rst_mid_hi", bus.HI, 32'd0);
    check_val("rst_mid_lo", bus.LO, 32'd0);

    // mtlo while busy is ignored
    cycle(1'b1, 4'd1, 32'd3, 32'd4);
    cycle(1'b1, 4'd8, 32'hDEAD_BEEF, 32'd0);
    idle(N_MULT);
    check_val("mtlo_ignored_lo", bus.LO, 32'd12);
    check_val("mtlo_ignored_hi", bus.HI, 32'd0);

    // randomized mix including ops issued while busy and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        r;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) op = 4'd0;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      if ($urandom_range(0, 5) == 0) a = -a;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) b = -b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      r = ($urandom_range(0, 299) != 0);
      cycle(r, op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
